// File: rtl/fifo_rd_drain.sv
// Async FIFO read-side drain: pops into a small skid buffer, streams valid/ready.
// Optional delivered-word counter enabled by RD_DRAIN_CNT_EN.
module fifo_rd_drain #(
  parameter int DSIZE     = 8,
  parameter int ADDRSIZE  = 4,
  parameter int BUF_DEPTH = 2,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DSIZE-1:0]    rdata,
  output logic                r_req,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DSIZE-1:0]    m_data,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty,
  output logic [31:0]         rd_beats
);

  localparam int IW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int PW = ADDRSIZE + 1;

  logic [IW-1:0]    head_q, head_d;
  logic [IW-1:0]    tail_q, tail_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [DSIZE-1:0] mem_q [BUF_DEPTH];
  logic [DSIZE-1:0] mem_d [BUF_DEPTH];
  logic             inflight_q, inflight_d;
  logic             m_valid_q, m_valid_d;
  logic [DSIZE-1:0] m_data_q, m_data_d;
  logic [PW-1:0]    rlevel_q, rlevel_d;
  logic             ae_q, ae_d;
  logic             deq;
  logic             cap;
  logic [OW:0]      need;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(BUF_DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    deq  = m_valid_q & m_ready;
    cap  = inflight_q;
    need = {1'b0, occ_q} + (OW+1)'(inflight_q)
         - (OW+1)'(deq);
    r_req      = need < (OW+1)'(BUF_DEPTH);
    inflight_d = r_req & ~rempty;
    occ_d  = occ_q + OW'(cap) - OW'(deq);
    head_d = deq ? nxt(head_q) : head_q;
    tail_d = cap ? nxt(tail_q) : tail_q;
    mem_d  = mem_q;
    if (cap) begin
      mem_d[tail_q] = rdata;
    end
    m_valid_d = (occ_d != '0);
    m_data_d  = m_data_q;
    // A word captured into an otherwise empty buffer bypasses the array
    if (m_valid_d) begin
      if (cap && (head_d == tail_q)) begin
        m_data_d = rdata;
      end else begin
        m_data_d = mem_q[head_d];
      end
    end
    rlevel_d = g2b(rq2_wptr) - g2b(rptr);
    ae_d     = (rlevel_d <= PW'(AE_THRESH));
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      rlevel_q   <= '0;
      ae_q       <= 1'b1;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      rlevel_q   <= rlevel_d;
      ae_q       <= ae_d;
      mem_q      <= mem_d;
    end
  end

`ifdef RD_DRAIN_CNT_EN
  logic [31:0] beats_q, beats_d;

  always_comb begin
    beats_d = beats_q + 32'(deq);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      beats_q <= '0;
    end else begin
      beats_q <= beats_d;
    end
  end

  assign rd_beats = beats_q;
`else
  assign rd_beats = '0;
`endif

  assign m_valid       = m_valid_q;
  assign m_data        = m_data_q;
  assign rlevel        = rlevel_q;
  assign ralmost_empty = ae_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: FIFO model feeds pops, scoreboard checks the stream.
module tb_fifo_rd_drain;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [4:0] rptr;
  logic [4:0] rq2_wptr;
  logic [7:0] rdata;
  logic       r_req;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [4:0] rlevel;
  logic       ralmost_empty;
  logic [31:0] rd_beats;

  fifo_rd_drain dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rempty        (rempty),
    .rptr          (rptr),
    .rq2_wptr      (rq2_wptr),
    .rdata         (rdata),
    .r_req         (r_req),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty),
    .rd_beats      (rd_beats)
  );

  always #5 rclk = ~rclk;

  int          n_checks;
  int          n_fail;
  logic [7:0]  fifo_q [$];
  logic [7:0]  exp_q [$];
  int          deq_cyc [$];
  logic [4:0]  wbin;
  logic [4:0]  rbin;
  logic        pend_v;
  logic [7:0]  pend_w;
  logic        stall_prev;
  logic [7:0]  stall_data;
  int          cyc;
  int          n_pop;
  int          n_deq;
  int          beats;
  int          first_pop_cyc;
  int          first_val_cyc;

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic all_done();
    return (fifo_q.size() == 0) && (exp_q.size() == 0);
  endfunction

  function automatic logic [31:0] exp_beats();
`ifdef RD_DRAIN_CNT_EN
    return 32'(beats);
`else
    return 32'd0;
`endif
  endfunction

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    wbin = wbin + 5'd1;
  endtask

  task automatic clr_stats();
    n_pop = 0;
    n_deq = 0;
    first_pop_cyc = -1;
    first_val_cyc = -1;
    deq_cyc.delete();
  endtask

  task automatic cycle(input logic rdy);
    logic [7:0] e;
    logic [7:0] w;
    @(negedge rclk);
    rdata    = pend_v ? pend_w : 8'($urandom);
    m_ready  = rdy;
    rempty   = (fifo_q.size() == 0);
    rptr     = b2g(rbin);
    rq2_wptr = b2g(wbin);
    #1;
    cyc++;
    if (stall_prev) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== stall_data) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b data=%h required 1/%h",
                 m_valid, m_data, stall_data);
      end
    end
    if (m_valid === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
    if (m_valid === 1'b1 && m_ready) begin
      n_checks++;
      n_deq++;
      beats++;
      deq_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_extra: data=%h required no word", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          n_fail++;
          $display("FAIL stream_data: got %h required %h", m_data, e);
        end
      end
    end
    pend_v = 1'b0;
    if (r_req === 1'b1 && !rempty) begin
      w = fifo_q.pop_front();
      exp_q.push_back(w);
      rbin = rbin + 5'd1;
      n_pop++;
      pend_v = 1'b1;
      pend_w = w;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    n_checks++;
    if (exp_q.size() > 2) begin
      n_fail++;
      $display("FAIL overflow: outstanding %0d required <= 2",
               exp_q.size());
    end
    stall_prev = m_valid && !m_ready;
    stall_data = m_data;
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    rempty = 1'b1;
    m_ready = 1'b0;
    rdata = 8'h00;
    rptr = '0;
    rq2_wptr = '0;
    @(negedge rclk);
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || rlevel !== 5'd0
        || ralmost_empty !== 1'b1 || r_req !== 1'b1
        || rd_beats !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b d=%h lvl=%0d ae=%b req=%b bt=%0d required 0/00/0/1/1/0",
               m_valid, m_data, rlevel, ralmost_empty, r_req, rd_beats);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    clr_stats();
    for (int i = 0; i < 10; i++) cycle(1'b0);
    n_checks++;
    if (n_pop != 0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_empty: pops=%0d valid=%b required 0/0",
               n_pop, m_valid);
    end
  endtask

  task automatic test_stream3();
    clr_stats();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    for (int i = 0; i < 20 && !all_done(); i++) cycle(1'b1);
    n_checks++;
    if (n_deq != 3) begin
      n_fail++;
      $display("FAIL s3_count: got %0d required 3", n_deq);
    end else begin
      n_checks++;
      if (first_val_cyc != first_pop_cyc + 2) begin
        n_fail++;
        $display("FAIL s3_latency: got %0d required %0d",
                 first_val_cyc - first_pop_cyc, 2);
      end
      n_checks++;
      if (deq_cyc[2] - deq_cyc[0] != 2) begin
        n_fail++;
        $display("FAIL s3_b2b: span %0d required 2",
                 deq_cyc[2] - deq_cyc[0]);
      end
    end
    n_checks++;
    if (rd_beats !== exp_beats()) begin
      n_fail++;
      $display("FAIL s3_beats: got %0d required %0d",
               rd_beats, exp_beats());
    end
  endtask

  task automatic test_backpressure();
    clr_stats();
    for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 6; i++) cycle(1'b0);
    n_checks++;
    if (n_pop != 2 || r_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_pops: pops=%0d req=%b required 2/0",
               n_pop, r_req);
    end
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b data=%h required 1/a0",
               m_valid, m_data);
    end
    for (int i = 0; i < 40 && !all_done(); i++) cycle(1'b1);
    n_checks++;
    if (n_deq != 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d required 8", n_deq);
    end else begin
      n_checks++;
      if (deq_cyc[7] - deq_cyc[0] != 7) begin
        n_fail++;
        $display("FAIL bp_rate: span %0d required 7",
                 deq_cyc[7] - deq_cyc[0]);
      end
    end
    n_checks++;
    if (rd_beats !== exp_beats()) begin
      n_fail++;
      $display("FAIL bp_beats: got %0d required %0d",
               rd_beats, exp_beats());
    end
  endtask

  task automatic test_toggle();
    clr_stats();
    for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i * 3));
    for (int i = 0; i < 100 && !all_done(); i++) cycle(i[0] == 1'b0);
    n_checks++;
    if (n_deq != 16 || n_pop != 16) begin
      n_fail++;
      $display("FAIL tog_count: deq=%0d pop=%0d required 16/16",
               n_deq, n_pop);
    end
  endtask

  task automatic test_ptr_wrap();
    rbin = 5'd30;
    wbin = 5'd1;
    cycle(1'b1);
    cycle(1'b1);
    n_checks++;
    if (rlevel !== 5'd3 || ralmost_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_3: lvl=%0d ae=%b required 3/0",
               rlevel, ralmost_empty);
    end
    rbin = 5'd31;
    cycle(1'b1);
    cycle(1'b1);
    n_checks++;
    if (rlevel !== 5'd2 || ralmost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_2: lvl=%0d ae=%b required 2/1",
               rlevel, ralmost_empty);
    end
    rbin = 5'd0;
    wbin = 5'd0;
  endtask

  task automatic test_reset_mid();
    clr_stats();
    for (int i = 0; i < 5; i++) push_word(8'hC0 + 8'(i));
    cycle(1'b0);
    cycle(1'b0);
    @(negedge rclk);
    rempty = 1'b1;
    #1;
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_prefill: valid=%b required 1", m_valid);
    end
    rrst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || rd_beats !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: v=%b d=%h bt=%0d required 0/00/0",
               m_valid, m_data, rd_beats);
    end
    @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    exp_q.delete();
    pend_v = 1'b0;
    stall_prev = 1'b0;
    beats = 0;
    clr_stats();
    for (int i = 0; i < 30 && !all_done(); i++) cycle(1'b1);
    n_checks++;
    if (n_deq != 3) begin
      n_fail++;
      $display("FAIL mid_after: got %0d words required 3", n_deq);
    end
    n_checks++;
    if (rd_beats !== exp_beats()) begin
      n_fail++;
      $display("FAIL mid_beats: got %0d required %0d",
               rd_beats, exp_beats());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    wbin = '0;
    rbin = '0;
    pend_v = 1'b0;
    pend_w = '0;
    stall_prev = 1'b0;
    stall_data = '0;
    cyc = 0;
    beats = 0;
    test_reset();
    test_stream3();
    test_backpressure();
    test_toggle();
    test_ptr_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
